// File: rtl/loop_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : loop_sdram_arbiter
// Function : Round-robin sharing of one SDRAM Avalon-MM slave among NCH loop
//            channels, with registered command lines and a bounded read wait.
// Revision : 1.0
// ============================================================================
module loop_sdram_arbiter #(
    parameter int NCH     = 4,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req_valid,
    input  logic [NCH-1:0]          req_write,
    input  logic [NCH*ADDR_W-1:0]   req_addr,
    input  logic [NCH*DATA_W-1:0]   req_wdata,
    output logic [NCH-1:0]          req_ready,
    output logic [NCH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic [ADDR_W-1:0]       avm_address,
    output logic [DATA_W-1:0]       avm_writedata,
    output logic                    avm_read_n,
    output logic                    avm_write_n,
    output logic                    avm_chipselect,
    output logic [3:0]              avm_byteenable_n,
    input  logic [DATA_W-1:0]       avm_readdata,
    input  logic                    avm_readdatavalid,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    err_sticky
);

    localparam int         RR_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RDWAIT = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [RR_W-1:0]     rr;
    logic [RR_W-1:0]     ch;
    logic [7:0]          cnt;

    logic                win_found;
    logic [RR_W-1:0]     win_idx;
    logic [RR_W-1:0]     cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic [NCH-1:0]      ch_onehot;

    logic                accept;
    logic                cmd_done;
    logic                rsp_ok;
    logic                rsp_to;
    logic                stray;

    // Scan downward so the candidate closest to rr+1 is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = RR_W'((int'(rr) + k) % NCH);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == RR_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    // Ready is gated by reset directly so it drops the instant reset asserts.
    always_comb begin
        req_ready = '0;
        if ((state == IDLE) && reset && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cmd_done  = 1'b0;
        rsp_ok    = 1'b0;
        rsp_to    = 1'b0;
        stray     = 1'b0;
        case (state)
            IDLE: begin
                stray = avm_readdatavalid;
                if (win_found) begin
                    accept    = 1'b1;
                    state_nxt = sel_write ? WR : RD;
                end
            end
            WR: begin
                stray = avm_readdatavalid;
                if (!avm_waitrequest) begin
                    cmd_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD: begin
                if (!avm_waitrequest) begin
                    cmd_done = 1'b1;
                    if (avm_readdatavalid) begin
                        rsp_ok    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    rsp_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == TO_LAST) begin
                    rsp_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr             <= RR_W'(NCH - 1);
            ch             <= '0;
            cnt            <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_read_n     <= 1'b1;
            avm_write_n    <= 1'b1;
            avm_chipselect <= 1'b0;
            err_sticky     <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            cnt       <= (state == RDWAIT) ? cnt + 8'd1 : 8'd0;
            if (accept) begin
                rr             <= win_idx;
                ch             <= win_idx;
                avm_address    <= sel_addr;
                avm_writedata  <= sel_wdata;
                avm_chipselect <= 1'b1;
                avm_write_n    <= ~sel_write;
                avm_read_n     <= sel_write;
            end
            if (cmd_done) begin
                avm_chipselect <= 1'b0;
                avm_write_n    <= 1'b1;
                avm_read_n     <= 1'b1;
            end
            if (rsp_ok) begin
                rsp_valid <= ch_onehot;
                rsp_data  <= avm_readdata;
            end
            if (rsp_to) begin
                rsp_valid  <= ch_onehot;
                rsp_err    <= 1'b1;
                rsp_data   <= '0;
                err_sticky <= 1'b1;
            end
            if (stray) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign busy             = (state != IDLE);
    assign avm_byteenable_n = 4'b0000;

endmodule
`default_nettype wire

// File: doc/loop_sdram_arbiter.md
# loop_sdram_arbiter

Shares the single SDRAM controller Avalon-MM slave port (the `system` SDRAM interface) among NCH loop-channel requesters. Each requester issues one-word record writes and playback reads. The block grants requests round-robin and holds each command until the controller drops waitrequest. It waits for readdatavalid, returning read data to the owning channel, and bounds every read with a timeout. It sits between the loop channel controllers and the SDRAM controller, replacing the direct `address`/`writedata`/`read_n`/`write_n` hookup.

## Interface
- NCH, 4, number of requesting channels (2..8)
- ADDR_W, 25, SDRAM word address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles from read acceptance to readdatavalid (8-bit counter)

Ports:
- clk  in  1  system clock (CLOCK_50); single clock domain
- reset  in  1  asynchronous, active-low (low = reset)
- req_valid  in  NCH  per-channel request pending
- req_write  in  NCH  1 = write, 0 = read
- req_addr  in  NCH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NCH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- req_ready  out  NCH  one-hot accept (combinational)
- rsp_valid  out  NCH  one-cycle read-return pulse, one-hot
- rsp_data  out  DATA_W  read data, valid with rsp_valid
- rsp_err  out  1  with rsp_valid: read timed out, rsp_data = 0
- avm_address  out  ADDR_W  to sdram_address
- avm_writedata  out  DATA_W
- avm_read_n  out  1  active-low read
- avm_write_n  out  1  active-low write
- avm_chipselect  out  1  high while a command is driven
- avm_byteenable_n  out  4  constant 4'b0000
- avm_readdata  in  DATA_W
- avm_readdatavalid  in  1
- avm_waitrequest  in  1
- busy  out  1  state != IDLE
- err_sticky  out  1  set on timeout or unsolicited readdatavalid; cleared only by reset

## Operation
- States: IDLE, WR, RD, RDWAIT.
- IDLE: the winner is the first channel with req_valid in the order rr+1, rr+2, …, rr (mod NCH).
  - req_ready[winner] = 1 combinationally, only in IDLE and only while reset is high.
  - On an edge with valid&ready, the block latches address, data, op and channel, and sets rr = winner.
  - The next state is WR or RD.
- WR: drive write_n=0, chipselect=1, address and writedata stable. On an edge with waitrequest=0, go to IDLE.
- RD: drive read_n=0, chipselect=1, address stable. On an edge with waitrequest=0:
  - If readdatavalid=1 on the same edge, complete (see RDWAIT).
  - Otherwise go to RDWAIT with the counter cleared.
- RDWAIT: command lines are deasserted and the counter increments each cycle.
  - On readdatavalid: register rsp_data = readdata, pulse rsp_valid[ch] and rsp_err = 0, go to IDLE.
  - If the counter reaches TIMEOUT first: pulse rsp_valid[ch] with rsp_err = 1 and rsp_data = 0, set err_sticky, go to IDLE.
- readdatavalid outside RD/RDWAIT is ignored and sets err_sticky.
- The waitrequest wait has no limit (the controller guarantees progress).
- Requesters hold req_* stable while req_valid is high and not yet accepted. Dropping req_valid before acceptance withdraws the request.
- Round-robin is fair: a continuously requesting channel waits at most NCH-1 grants.
- Reset values:
  - req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0.
  - avm_read_n 1, avm_write_n 1, avm_chipselect 0, avm_address 0, avm_writedata 0.
  - busy 0, err_sticky 0, rr = NCH-1 (channel 0 wins first), state IDLE.
- Reset asserted mid-operation: all outputs go to reset values immediately and any outstanding read is abandoned without a response.

## Timing
- Accept at edge k. The command is visible from cycle k+1, with all avm outputs registered.
- Write with waitrequest low: the command lasts 1 cycle, IDLE at k+2, next accept at edge k+2. Peak rate is 1 write per 2 cycles.
- Write with waitrequest high for W cycles: the command holds W+1 cycles.
- Read with controller latency L (readdatavalid L cycles after command acceptance): rsp_valid appears in the cycle after readdatavalid is sampled.
- rsp_valid is one cycle wide and registered. rsp_data holds its value until the next response.
- Simultaneous requests in IDLE: exactly one req_ready bit is high. Ties are resolved only by rr.

## Test plan
- Reset: hold reset low with all req_valid=1 -> req_ready=0, read_n=write_n=1, chipselect=0. Release -> channel 0 accepted first.
- Single write: ch2 writes addr 0x0001234, data 0xDEADBEEF, waitrequest low -> write_n low for exactly 1 cycle with that addr/data. busy falls 2 cycles after acceptance.
- Read with waitrequest held 3 cycles and L=4: ch1 reads 0x0000100 returning 0x00ABCDEF -> read_n low 4 cycles, then rsp_valid[1]=1 for one cycle with rsp_data 0x00ABCDEF and rsp_err=0.
- Round-robin: all 4 channels request writes continuously -> grant order 0,1,2,3,0,1. Drop ch2 mid-run -> order continues 3,0,1,3.
- Timeout: read issued, readdatavalid never asserted -> after 255 RDWAIT cycles rsp_valid[ch]=1, rsp_err=1, rsp_data=0, err_sticky=1. A late readdatavalid in IDLE is ignored.
- Reset mid-read: reset low during RDWAIT -> no rsp_valid. After release, state is IDLE and a new ch3 request is accepted normally.
